// File: rtl/spi_pkg.sv
// Shared types and divisor arithmetic for the SPI serial-clock engine.
// Pure declarations; no state and no timing of its own.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    RUN   = 2'd2,
    TRAIL = 2'd3
  } state_e;

  function automatic int div_width(input int sppr_w, input int spr_w);
    return sppr_w + (1 << spr_w) + 1;
  endfunction

  localparam int SPPR_W_DEF = 3;
  localparam int SPR_W_DEF  = 3;
  localparam int DIV_W_DEF  = div_width(SPPR_W_DEF, SPR_W_DEF);

  // Divisor = (sppr+1) << (spr+1); callers truncate to their DIV_W.
  function automatic logic [63:0] calc_divisor(input logic [31:0] sppr, input logic [31:0] spr);
    return (64'(sppr) + 64'd1) << (spr + 32'd1);
  endfunction

endpackage

// File: rtl/spi_sclk_engine_if.sv
// Control-register and shift-register side signals of the SPI clock engine.
// master drives the request/config inputs; slave is the engine itself.
interface spi_sclk_engine_if #(
  parameter int SPPR_W   = 3,
  parameter int SPR_W    = 3,
  parameter int MAX_BITS = 16
) ();
  localparam int DIV_W = spi_pkg::div_width(SPPR_W, SPR_W);
  localparam int LEN_W = $clog2(MAX_BITS + 1);

  logic              start;
  logic [LEN_W-1:0]  xfer_bits;
  logic              cpol;
  logic              cpha;
  logic              ss;
  logic              spiswai;
  logic [SPPR_W-1:0] sppr;
  logic [SPR_W-1:0]  spr;
  logic              sclk;
  logic              sample_stb;
  logic              shift_stb;
  logic              busy;
  logic              done;
  logic              abort;
  logic [DIV_W-1:0]  baud_rate_divisor;

  modport master (
    output start, xfer_bits, cpol, cpha, ss, spiswai, sppr, spr,
    input  sclk, sample_stb, shift_stb, busy, done, abort, baud_rate_divisor
  );

  modport slave (
    input  start, xfer_bits, cpol, cpha, ss, spiswai, sppr, spr,
    output sclk, sample_stb, shift_stb, busy, done, abort, baud_rate_divisor
  );
endinterface

// File: rtl/spi_half_period_tick.sv
// Half-period timer: counts 0..half-1 on enabled cycles and ticks on the last count.
// load latches a new half period and restarts; clr restarts; en low freezes the count.
module spi_half_period_tick #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             clr,
  input  logic [CNT_W-1:0] half,
  output logic             tick
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;

  always_comb begin
    tick   = en && (cnt_q == half_q - CNT_W'(1));
    half_d = load ? half : half_q;
    cnt_d  = cnt_q;
    if (load || clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      half_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
    end
  end
endmodule

// File: rtl/spi_sclk_engine.sv
// SPI SCLK engine: divisor, framed LEAD/RUN/TRAIL transfers, mode-correct strobes.
// Outputs registered (1-cycle); spiswai freezes progress; ss high aborts next cycle.
module spi_sclk_engine
  import spi_pkg::*;
#(
  parameter int SPPR_W   = 3,
  parameter int SPR_W    = 3,
  parameter int MAX_BITS = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  spi_sclk_engine_if.slave  bus
);
  localparam int DIV_W = div_width(SPPR_W, SPR_W);
  localparam int LEN_W = $clog2(MAX_BITS + 1);
  localparam int H_W   = DIV_W - 1;
  localparam int E_W   = LEN_W + 1;

  state_e           state_q, state_d;
  logic             sclk_q, sclk_d;
  logic             sample_q, sample_d;
  logic             shift_q, shift_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [LEN_W-1:0] nbits_q, nbits_d;
  logic [E_W-1:0]   edge_q, edge_d;

  logic             accept, abort_now, run_en, tick;
  logic [H_W-1:0]   half;
  logic [E_W-1:0]   next_edge;
  logic             leading, last_edge;

  assign accept    = bus.start && (state_q == IDLE) && !bus.ss && (bus.xfer_bits != '0);
  assign abort_now = (state_q != IDLE) && bus.ss;
  assign run_en    = (state_q != IDLE) && !bus.spiswai && !abort_now;
  assign half      = div_q[DIV_W-1:1];

  spi_half_period_tick #(.CNT_W(H_W)) u_tick (
    .clk  (PCLK),
    .rst  (PRESET),
    .en   (run_en),
    .load (accept),
    .clr  (abort_now),
    .half (half),
    .tick (tick)
  );

  always_comb begin
    div_d     = DIV_W'(calc_divisor(32'(bus.sppr), 32'(bus.spr)));
    state_d   = state_q;
    sclk_d    = sclk_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    nbits_d   = nbits_q;
    edge_d    = edge_q;
    sample_d  = 1'b0;
    shift_d   = 1'b0;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    next_edge = edge_q + E_W'(1);
    leading   = next_edge[0];
    last_edge = (next_edge == {nbits_q, 1'b0});

    if (abort_now) begin
      state_d = IDLE;
      sclk_d  = bus.cpol;
      abort_d = 1'b1;
      edge_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.spiswai) sclk_d = bus.cpol;
          if (accept) begin
            state_d = LEAD;
            sclk_d  = bus.cpol;
            cpol_d  = bus.cpol;
            cpha_d  = bus.cpha;
            edge_d  = '0;
            nbits_d = (bus.xfer_bits > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : bus.xfer_bits;
          end
        end
        LEAD: begin
          if (tick) state_d = RUN;
        end
        RUN: begin
          // Strobe flops load with sclk so both show the new level in the same cycle.
          if (tick) begin
            sclk_d = ~sclk_q;
            edge_d = next_edge;
            if (cpha_q) begin
              shift_d  = leading;
              sample_d = !leading;
            end else begin
              sample_d = leading;
              shift_d  = !leading && !last_edge;
            end
            if (last_edge) state_d = TRAIL;
          end
        end
        TRAIL: begin
          if (tick) begin
            state_d = IDLE;
            sclk_d  = cpol_q;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      sclk_q   <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      div_q    <= DIV_W'(2);
      nbits_q  <= '0;
      edge_q   <= '0;
    end else begin
      state_q  <= state_d;
      sclk_q   <= sclk_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      div_q    <= div_d;
      nbits_q  <= nbits_d;
      edge_q   <= edge_d;
    end
  end

  assign bus.sclk              = sclk_q;
  assign bus.sample_stb        = sample_q;
  assign bus.shift_stb         = shift_q;
  assign bus.busy              = (state_q != IDLE);
  assign bus.done              = done_q;
  assign bus.abort             = abort_q;
  assign bus.baud_rate_divisor = div_q;
endmodule
